// File: rtl/line_scheduler.sv
// line_scheduler: drives fifo_solver over every grid line (rows, then columns), pruning
// per-line live-option masks until each line commits. Define LSCHED_WDOG_EN for the response watchdog.
module line_scheduler #(
  parameter  int SIZE     = 3,
  parameter  int MAX_OPTS = 8,
  parameter  int OPTW     = 4,
  parameter  int WDOG_CYC = 64,
  localparam int LW       = $clog2(2*SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [LW-1:0]     cfg_line,
  input  logic [OPTW-1:0]   cfg_cnt,
  input  logic              start,
  output logic              opt_req,
  output logic [LW-1:0]     opt_line,
  output logic [OPTW-1:0]   opt_idx,
  input  logic              opt_rvalid,
  input  logic [SIZE-1:0]   opt_rdata,
  output logic              sol_valid_op,
  output logic [SIZE-1:0]   sol_option,
  output logic [SIZE-1:0]   sol_line_ind,
  output logic              sol_row,
  output logic [SIZE:0]     sol_option_num,
  input  logic              sol_valid_out,
  input  logic              sol_put_back,
  output logic              busy,
  output logic              solved,
  output logic              stuck,
  output logic              failed,
  output logic [2*SIZE-1:0] committed
);

  localparam int NL = 2*SIZE;
  localparam int NW = SIZE + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_FETCH, S_ISSUE, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t              state;
  logic [MAX_OPTS-1:0] mask [NL];
  logic [LW-1:0]       ptr, line;
  logic [OPTW-1:0]     cursor, line_cnt;
  logic                progress, wrap_pend;

  // Returns {found, index} of the lowest set bit at or above position from.
  function automatic logic [OPTW:0] first_set(input logic [MAX_OPTS-1:0] m, input int from);
    first_set = '0;
    for (int b = MAX_OPTS-1; b >= 0; b--)
      if (m[b] && b >= from) first_set = {1'b1, OPTW'(b)};
  endfunction

  function automatic logic [OPTW-1:0] popcount(input logic [MAX_OPTS-1:0] m);
    popcount = '0;
    for (int b = 0; b < MAX_OPTS; b++) popcount = popcount + OPTW'(m[b]);
  endfunction

  logic                hi_found, lo_found, pick_found, pick_wrap, line_last;
  logic [LW-1:0]       hi_line, lo_line, pick_line, line_inc;
  logic [MAX_OPTS-1:0] pick_mask, cur_bit, pruned, cfg_mask;
  logic [OPTW:0]       pick_first, next_first;
  logic [OPTW-1:0]     pick_cnt;
  logic [SIZE-1:0]     line_ind;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_line  = '0;
    lo_line  = '0;
    for (int i = NL-1; i >= 0; i--) begin
      if (!committed[i]) begin
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_line  = LW'(i);
        end else begin
          lo_found = 1'b1;
          lo_line  = LW'(i);
        end
      end
    end
  end

  // Counts above MAX_OPTS saturate for free: every bit index is below them.
  always_comb begin
    cfg_mask = '0;
    for (int b = 0; b < MAX_OPTS; b++) cfg_mask[b] = (b < int'(cfg_cnt));
  end

  assign pick_found = hi_found | lo_found;
  assign pick_wrap  = wrap_pend | ~hi_found;
  assign pick_line  = hi_found ? hi_line : lo_line;
  assign pick_mask  = mask[pick_line];
  assign pick_first = first_set(pick_mask, 0);
  assign pick_cnt   = popcount(pick_mask);
  assign cur_bit    = MAX_OPTS'(1) << cursor;
  assign pruned     = mask[line] & ~cur_bit;
  assign next_first = first_set(mask[line], int'(cursor) + 1);
  assign line_last  = (line == LW'(NL-1));
  assign line_inc   = line_last ? '0 : line + LW'(1);
  assign line_ind   = (int'(line) >= SIZE) ? SIZE'(int'(line) - SIZE) : SIZE'(line);
  assign busy       = (state != S_IDLE) && (state != S_DONE);

`ifdef LSCHED_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] wdog;
  logic           wdog_fire;
  assign wdog_fire = ((state == S_FETCH && !opt_rvalid) || (state == S_WAIT && !sol_valid_out))
                     && (wdog == WDW'(WDOG_CYC - 1));
`else
  // WDOG_CYC has no role without the watchdog.
  logic [31:0] wdog_unused;
  assign wdog_unused = WDOG_CYC;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      // NOTE: the mask store is reset explicitly because a run may start before any cfg_wr.
      for (int i = 0; i < NL; i++) mask[i] <= '0;
      ptr            <= '0;
      line           <= '0;
      cursor         <= '0;
      line_cnt       <= '0;
      progress       <= 1'b0;
      wrap_pend      <= 1'b0;
      opt_req        <= 1'b0;
      opt_line       <= '0;
      opt_idx        <= '0;
      sol_valid_op   <= 1'b0;
      sol_option     <= '0;
      sol_line_ind   <= '0;
      sol_row        <= 1'b0;
      sol_option_num <= '0;
      solved         <= 1'b0;
      stuck          <= 1'b0;
      failed         <= 1'b0;
      committed      <= '0;
`ifdef LSCHED_WDOG_EN
      wdog           <= '0;
`endif
    end else begin
      opt_req      <= 1'b0;
      sol_valid_op <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (cfg_wr && int'(cfg_line) < NL) mask[cfg_line] <= cfg_mask;
          if (start) begin
            state     <= S_PICK;
            ptr       <= '0;
            cursor    <= '0;
            progress  <= 1'b0;
            wrap_pend <= 1'b0;
            committed <= '0;
            solved    <= 1'b0;
            stuck     <= 1'b0;
            failed    <= 1'b0;
          end
        end
        S_PICK: begin
          if (!pick_found) begin
            solved <= 1'b1;
            state  <= S_DONE;
          end else if (pick_wrap && !progress) begin
            stuck <= 1'b1;
            state <= S_DONE;
          end else begin
            if (pick_wrap) progress <= 1'b0;
            wrap_pend <= 1'b0;
            line      <= pick_line;
            line_cnt  <= pick_cnt;
            if (!pick_first[OPTW]) begin
              failed <= 1'b1;
              state  <= S_DONE;
            end else begin
              cursor   <= pick_first[OPTW-1:0];
              opt_req  <= 1'b1;
              opt_line <= pick_line;
              opt_idx  <= pick_first[OPTW-1:0];
              state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (opt_rvalid) begin
            sol_option     <= opt_rdata;
            sol_line_ind   <= line_ind;
            sol_row        <= (int'(line) < SIZE);
            sol_option_num <= NW'(line_cnt);
            sol_valid_op   <= 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (sol_valid_out) begin
            if (line_cnt == OPTW'(1)) begin
              committed[line] <= 1'b1;
              progress        <= 1'b1;
              ptr             <= line_inc;
              wrap_pend       <= line_last;
              state           <= S_PICK;
            end else if (!sol_put_back) begin
              mask[line] <= pruned;
              progress   <= 1'b1;
              if (pruned == '0) begin
                failed <= 1'b1;
                state  <= S_DONE;
              end else begin
                state <= S_NEXT;
              end
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (next_first[OPTW]) begin
            cursor   <= next_first[OPTW-1:0];
            opt_req  <= 1'b1;
            opt_line <= line;
            opt_idx  <= next_first[OPTW-1:0];
            state    <= S_FETCH;
          end else begin
            ptr       <= line_inc;
            wrap_pend <= line_last;
            state     <= S_PICK;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef LSCHED_WDOG_EN
      // Only FETCH and WAIT count, so the counter is already zero on every entry.
      wdog <= (state == S_FETCH || state == S_WAIT) ? wdog + WDW'(1) : '0;
      if (wdog_fire) begin
        failed <= 1'b1;
        state  <= S_DONE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_line_scheduler.sv
// Directed bench for line_scheduler: memory and solver models with a scoreboard of expected issues.
module tb_line_scheduler;
  localparam int SIZE     = 3;
  localparam int MAX_OPTS = 8;
  localparam int OPTW     = 4;
  localparam int NL       = 2*SIZE;
  localparam int LW       = $clog2(NL);

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              cfg_wr = 1'b0, start = 1'b0;
  logic [LW-1:0]     cfg_line = '0;
  logic [OPTW-1:0]   cfg_cnt = '0;
  logic              opt_req, opt_rvalid;
  logic [LW-1:0]     opt_line;
  logic [OPTW-1:0]   opt_idx;
  logic [SIZE-1:0]   opt_rdata;
  logic              sol_valid_op, sol_row, sol_valid_out, sol_put_back;
  logic [SIZE-1:0]   sol_option, sol_line_ind;
  logic [SIZE:0]     sol_option_num;
  logic              busy, solved, stuck, failed;
  logic [NL-1:0]     committed;

  typedef struct {int line; int idx; int num;} exp_t;
  exp_t sb[$];
  exp_t e_cur;

  int  checks = 0, errors = 0;
  int  mem_lat = 1, sol_lat = 1;
  bit  sol_hold = 1'b0;
  bit  contra [NL][MAX_OPTS];
  int  cyc = 0, req_cyc = 0, issue_cyc = 0, req_line = 0, req_idx = 0, n_issue = 0;
  int  base, fail_cyc, n;

  line_scheduler #(.SIZE(SIZE), .MAX_OPTS(MAX_OPTS), .OPTW(OPTW), .WDOG_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_line(cfg_line), .cfg_cnt(cfg_cnt),
    .start(start), .opt_req(opt_req), .opt_line(opt_line), .opt_idx(opt_idx),
    .opt_rvalid(opt_rvalid), .opt_rdata(opt_rdata), .sol_valid_op(sol_valid_op),
    .sol_option(sol_option), .sol_line_ind(sol_line_ind), .sol_row(sol_row),
    .sol_option_num(sol_option_num), .sol_valid_out(sol_valid_out), .sol_put_back(sol_put_back),
    .busy(busy), .solved(solved), .stuck(stuck), .failed(failed), .committed(committed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [SIZE-1:0] pat(input int l, input int i);
    return SIZE'(l*3 + i + 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int l, input int i, input int num);
    exp_t e;
    e.line = l; e.idx = i; e.num = num;
    sb.push_back(e);
  endtask

  task automatic cfg(input int l, input int cnt);
    cfg_wr = 1'b1; cfg_line = LW'(l); cfg_cnt = OPTW'(cnt);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {opt_req, opt_line, opt_idx, sol_valid_op, sol_option, sol_line_ind, sol_row,
                sol_option_num, busy, solved, stuck, failed, committed}, 0);
  endtask

  // Option memory model: fixed latency, payload derived from line and index.
  initial begin
    opt_rvalid = 1'b0;
    opt_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && opt_req) begin
        req_line = int'(opt_line);
        req_idx  = int'(opt_idx);
        req_cyc  = cyc;
        check("sb_nonempty_req", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          check("req_line", opt_line, sb[0].line);
          check("req_idx", opt_idx, sb[0].idx);
        end
        repeat (mem_lat) @(negedge clk);
        opt_rvalid = 1'b1;
        opt_rdata  = pat(req_line, req_idx);
        @(negedge clk);
        opt_rvalid = 1'b0;
      end
    end
  end

  // Solver model: pops the scoreboard on each issue and answers from the contradiction table.
  initial begin
    sol_valid_out = 1'b0;
    sol_put_back  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && sol_valid_op) begin
        n_issue++;
        issue_cyc = cyc;
        check("sb_nonempty_issue", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e_cur = sb.pop_front();
          check("issue_option", sol_option, pat(e_cur.line, e_cur.idx));
          check("issue_line_ind", sol_line_ind, e_cur.line % SIZE);
          check("issue_row", sol_row, e_cur.line < SIZE);
          check("issue_num", sol_option_num, e_cur.num);
        end
        check("issue_latency", cyc - req_cyc, mem_lat + 1);
        if (!sol_hold) begin
          repeat (sol_lat) @(negedge clk);
          check("option_stable", sol_option, pat(req_line, req_idx));
          sol_valid_out = 1'b1;
          sol_put_back  = !contra[req_line][req_idx];
          @(negedge clk);
          sol_valid_out = 1'b0;
          sol_put_back  = 1'b0;
        end
      end
    end
  end

  initial begin
    foreach (contra[l, i]) contra[l][i] = 1'b0;
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All lines single-option: every line commits on its first issue.
    for (int l = 0; l < NL; l++) cfg(l, 1);
    for (int l = 0; l < NL; l++) push(l, 0, 1);
    base = n_issue;
    start_pulse();
    wait_done("t1_done", 500);
    check("t1_issues", n_issue - base, 6);
    check("t1_solved", solved, 1);
    check("t1_flags", {stuck, failed}, 0);
    check("t1_committed", committed, 6'b111111);

    // Row 0 with three options, first two contradicted.
    cfg(0, 3);
    contra[0][0] = 1'b1;
    contra[0][1] = 1'b1;
    push(0, 0, 3); push(0, 1, 3); push(0, 2, 3);
    for (int l = 1; l < NL; l++) push(l, 0, 1);
    push(0, 2, 1);
    base = n_issue;
    start_pulse();
    wait_done("t2_done", 800);
    check("t2_issues", n_issue - base, 9);
    check("t2_solved", solved, 1);
    check("t2_committed", committed, 6'b111111);
    contra[0][0] = 1'b0;
    contra[0][1] = 1'b0;

    // Two options everywhere, solver never contradicts: no progress in a full pass.
    for (int l = 0; l < NL; l++) cfg(l, 2);
    for (int l = 0; l < NL; l++) begin push(l, 0, 2); push(l, 1, 2); end
    base = n_issue;
    start_pulse();
    wait_done("t3_done", 1000);
    check("t3_issues", n_issue - base, 12);
    check("t3_stuck", stuck, 1);
    check("t3_solved_failed", {solved, failed}, 0);
    check("t3_committed", committed, 0);

    // Row 1 loses both options.
    for (int l = 0; l < NL; l++) cfg(l, 1);
    cfg(1, 2);
    contra[1][0] = 1'b1;
    contra[1][1] = 1'b1;
    push(0, 0, 1); push(1, 0, 2); push(1, 1, 2);
    base = n_issue;
    start_pulse();
    wait_done("t4_done", 500);
    check("t4_issues", n_issue - base, 3);
    check("t4_failed", failed, 1);
    check("t4_solved", solved, 0);
    check("t4_committed", committed, 6'b000001);
    contra[1][0] = 1'b0;
    contra[1][1] = 1'b0;

    // Slow memory and solver; start and cfg_wr while busy must be ignored.
    mem_lat = 5;
    sol_lat = 3;
    for (int l = 0; l < NL; l++) cfg(l, 1);
    for (int l = 0; l < NL; l++) push(l, 0, 1);
    base = n_issue;
    start_pulse();
    repeat (8) @(negedge clk);
    check("t5_busy_mid", busy, 1);
    start_pulse();
    cfg(5, 0);
    wait_done("t5_done", 1000);
    check("t5_issues", n_issue - base, 6);
    check("t5_solved", solved, 1);
    check("t5_committed", committed, 6'b111111);
    mem_lat = 1;
    sol_lat = 1;

    // Saturating count on row 0: eight live options never pruned, other lines commit.
    cfg(0, 15);
    for (int i = 0; i < MAX_OPTS; i++) push(0, i, 8);
    for (int l = 1; l < NL; l++) push(l, 0, 1);
    for (int i = 0; i < MAX_OPTS; i++) push(0, i, 8);
    base = n_issue;
    start_pulse();
    wait_done("t6_done", 2000);
    check("t6_issues", n_issue - base, 21);
    check("t6_stuck", stuck, 1);
    check("t6_committed", committed, 6'b111110);
    check("t6_solved_failed", {solved, failed}, 0);

    // Same-cycle cfg_wr (empty line 2) and start: start sees the new mask.
    cfg(0, 1);
    cfg_wr = 1'b1; cfg_line = LW'(2); cfg_cnt = '0; start = 1'b1;
    push(0, 0, 1); push(1, 0, 1);
    base = n_issue;
    @(negedge clk);
    cfg_wr = 1'b0; start = 1'b0;
    wait_done("t7_done", 500);
    check("t7_issues", n_issue - base, 2);
    check("t7_failed", failed, 1);
    check("t7_committed", committed, 6'b000011);

    // Solver never answers.
    cfg(2, 1);
    sol_hold = 1'b1;
    push(0, 0, 1);
    start_pulse();
`ifdef LSCHED_WDOG_EN
    n = 0;
    while (failed !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    fail_cyc = cyc;
    check("wdog_failed", failed, 1);
    check("wdog_cycles", fail_cyc - issue_cyc, 17);
    check("wdog_busy", busy, 0);
    push(0, 0, 1);
    start_pulse();
    repeat (6) @(negedge clk);
`else
    repeat (100) @(negedge clk);
    check("hold_failed", failed, 0);
`endif
    check("hold_busy", busy, 1);

    // Asynchronous reset in the middle of a run.
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    sb.delete();
    sol_hold = 1'b0;
    check_all_zero("post_reset_outputs");

    // Masks were cleared by reset: line 0 is empty on the first pick.
    base = n_issue;
    start_pulse();
    wait_done("t9_done", 100);
    check("t9_failed", failed, 1);
    check("t9_issues", n_issue - base, 0);
    check("t9_committed", committed, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
